// File: rtl/btb_nway_plru.sv
// btb_nway_plru: set-associative branch target buffer with per-lane ways,
// ASID tagging, tree-PLRU replacement and a one-set-per-cycle flush sweep.
module btb_nway_plru #(
    parameter int SETS    = 256,
    parameter int WAYS    = 4,
    parameter int LANES   = 8,
    parameter int TAG_W   = 10,
    parameter int ASID_W  = 9,
    parameter int ENTRY_W = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [ASID_W-1:0]             i_arch_asid,
    input  logic                          i_read_req_valid,
    input  logic [$clog2(SETS)-1:0]       i_read_req_index,
    input  logic [TAG_W-1:0]              i_read_req_tag,
    output logic                          o_read_resp_valid,
    output logic [LANES*ENTRY_W-1:0]      o_read_resp_entry_by_lane,
    output logic [LANES-1:0]              o_read_resp_hit_by_lane,
    output logic [LANES*$clog2(WAYS)-1:0] o_read_resp_hit_way_by_lane,
    input  logic                          i_update_valid,
    input  logic [$clog2(SETS)-1:0]       i_update_index,
    input  logic [$clog2(LANES)-1:0]      i_update_lane,
    input  logic [TAG_W-1:0]              i_update_tag,
    input  logic [ENTRY_W-1:0]            i_update_entry,
    input  logic                          i_update_hit,
    input  logic [$clog2(WAYS)-1:0]       i_update_hit_way,
    input  logic                          i_flush_req,
    output logic                          o_flush_busy
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    // Entry storage; valid and PLRU are kept as whole-set rows so a flush
    // clears one set with a single write.
    logic [TAG_W-1:0]              r_tag   [SETS][LANES][WAYS];
    logic [ASID_W-1:0]             r_asid  [SETS][LANES][WAYS];
    logic [ENTRY_W-1:0]            r_entry [SETS][LANES][WAYS];
    logic [LANES-1:0][WAYS-1:0]    r_valid [SETS];
    logic [LANES-1:0][WAYS-2:0]    r_plru  [SETS];

    state_t                        r_state, w_stateNext;
    logic [IDX_W-1:0]              r_flushCnt, w_flushCntNext;
    logic                          w_flushing;

    logic [LANES-1:0]              w_rdHit, r_respHit;
    logic [LANES-1:0][WAY_W-1:0]   w_rdWay, r_respWay;
    logic [LANES-1:0][ENTRY_W-1:0] w_rdEntry, r_respEntry;
    logic                          r_respValid;
    logic [IDX_W-1:0]              r_respIndex;

    logic                          w_updEn;
    logic [WAY_W-1:0]              w_victim, w_updWay;
    logic [WAYS-1:0]               w_updValidWays;
    logic [LANES-1:0][WAYS-2:0]    w_plruTouchRow, w_plruUpdRow;
    logic [LANES-1:0][WAYS-1:0]    w_validRow;

    // Tree bit = 1 means the victim lies in the right subtree.
    function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] bits);
        int   node;
        logic b;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b    = |((bits >> node) & (WAYS-1)'(1));
            node = 2 * node + 1 + int'(b);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    // Make the given way MRU: every node on its path points away from it.
    function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0]  bits,
                                                  input logic [WAY_W-1:0] way);
        int              node;
        logic            dir;
        logic [WAYS-2:0] mask;
        logic [WAYS-2:0] res;
        res  = bits;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir  = |((way >> (WAY_W - 1 - lvl)) & WAY_W'(1));
            mask = (WAYS-1)'(1) << node;
            res  = dir ? (res & ~mask) : (res | mask);
            node = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    assign w_flushing = (r_state == ST_FLUSH);
    assign w_updEn    = i_update_valid && !w_flushing;

    // State register and sweep counter; reset starts a full sweep.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_FLUSH;
            r_flushCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_flushCnt <= w_flushCntNext;
        end
    end

    // Next-state logic: sweep one set per cycle, ignore flush requests mid-sweep.
    always_comb begin
        w_stateNext    = r_state;
        w_flushCntNext = r_flushCnt;
        case (r_state)
            ST_IDLE: begin
                if (i_flush_req) begin
                    w_stateNext    = ST_FLUSH;
                    w_flushCntNext = '0;
                end
            end
            ST_FLUSH: begin
                w_flushCntNext = r_flushCnt + IDX_W'(1);
                if (r_flushCnt == IDX_W'(SETS - 1)) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Tag/ASID lookup on the requested set; scanning downward lets the lowest hitting way win.
    always_comb begin
        w_rdHit   = '0;
        w_rdWay   = '0;
        w_rdEntry = '0;
        if (i_read_req_valid && !w_flushing) begin
            for (int l = 0; l < LANES; l++) begin
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (r_valid[i_read_req_index][l][w] &&
                        r_tag[i_read_req_index][l][w] == i_read_req_tag &&
                        r_asid[i_read_req_index][l][w] == i_arch_asid) begin
                        w_rdHit[l]   = 1'b1;
                        w_rdWay[l]   = WAY_W'(w);
                        w_rdEntry[l] = r_entry[i_read_req_index][l][w];
                    end
                end
            end
        end
    end

    // Register the lookup so the response (and its PLRU touch) lands one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_respValid <= 1'b0;
            r_respHit   <= '0;
            r_respWay   <= '0;
            r_respEntry <= '0;
            r_respIndex <= '0;
        end else begin
            r_respValid <= i_read_req_valid;
            r_respHit   <= w_rdHit;
            r_respWay   <= w_rdWay;
            r_respEntry <= w_rdEntry;
            r_respIndex <= i_read_req_index;
        end
    end

    // Victim choice: lowest invalid way, otherwise the PLRU pick.
    always_comb begin
        w_updValidWays = r_valid[i_update_index][i_update_lane];
        w_victim       = plruVictim(r_plru[i_update_index][i_update_lane]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_updValidWays[w]) begin
                w_victim = WAY_W'(w);
            end
        end
        w_updWay = i_update_hit ? i_update_hit_way : w_victim;
    end

    // Build the PLRU/valid rows; an update on the same (set, lane) suppresses that lane's read touch.
    always_comb begin
        w_plruTouchRow = r_plru[r_respIndex];
        for (int l = 0; l < LANES; l++) begin
            if (r_respHit[l] &&
                !(w_updEn && i_update_index == r_respIndex && i_update_lane == LANE_W'(l))) begin
                w_plruTouchRow[l] = plruTouch(r_plru[r_respIndex][l], r_respWay[l]);
            end
        end
        w_plruUpdRow = ((|r_respHit) && i_update_index == r_respIndex) ?
                       w_plruTouchRow : r_plru[i_update_index];
        w_plruUpdRow[i_update_lane] = plruTouch(r_plru[i_update_index][i_update_lane], w_updWay);
        w_validRow = r_valid[i_update_index];
        w_validRow[i_update_lane][w_updWay] = 1'b1;
    end

    // Valid/PLRU writes in priority order: read touch, then update, then flush clear.
    always_ff @(posedge i_clk) begin
        if (|r_respHit) begin
            r_plru[r_respIndex] <= w_plruTouchRow;
        end
        if (w_updEn) begin
            r_plru[i_update_index]  <= w_plruUpdRow;
            r_valid[i_update_index] <= w_validRow;
        end
        if (w_flushing) begin
            r_plru[r_flushCnt]  <= '0;
            r_valid[r_flushCnt] <= '0;
        end
    end

    // Payload fields of the written way.
    always_ff @(posedge i_clk) begin
        if (w_updEn) begin
            r_tag[i_update_index][i_update_lane][w_updWay]   <= i_update_tag;
            r_asid[i_update_index][i_update_lane][w_updWay]  <= i_arch_asid;
            r_entry[i_update_index][i_update_lane][w_updWay] <= i_update_entry;
        end
    end

    assign o_read_resp_valid           = r_respValid;
    assign o_read_resp_hit_by_lane     = r_respHit;
    assign o_read_resp_hit_way_by_lane = r_respWay;
    assign o_read_resp_entry_by_lane   = r_respEntry;
    assign o_flush_busy                = w_flushing;

endmodule
